uart_rx_framed: RTL

//  Parametrised UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits.

---
 rtl/uart_rx_framed.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// UART receiver with 3-sample mid-bit majority voting, optional parity, 1/2 stop bits,
// break/overrun reporting and a single held output word with a valid/ready handshake.
module uart_rx_framed #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    rx_ready,
    output logic                    rx_valid,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_parity_err,
    output logic                    rx_frame_err,
    output logic                    rx_break,
    output logic                    rx_overrun
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(PAYLOAD_BITS);

    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_S0   = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(CPB / 2);
    localparam logic [CW-1:0] C_DEC  = CW'(CPB / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                  state_q;
    logic [1:0]              sync_q;
    logic [CW-1:0]           cnt_q;
    logic [1:0]              smp_q;
    logic [BW-1:0]           bit_q;
    logic                    stop_q;
    logic [PAYLOAD_BITS-1:0] data_q;
    logic                    pbit_q;
    logic                    stop0_q;
    logic                    ferr_q;

    logic                    valid_q;
    logic [PAYLOAD_BITS-1:0] dout_q;
    logic                    perr_out_q;
    logic                    ferr_out_q;
    logic                    brk_q;
    logic                    ovr_q;

    logic rxs, maj, at_dec, at_end, last_stop, first_stop, fr_err, par_err, is_brk;

    assign rxs = sync_q[1];

    always_comb begin
        maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
        at_dec     = (cnt_q == C_DEC);
        at_end     = (cnt_q == C_LAST);
        last_stop  = (STOP_BITS == 1) || stop_q;
        // On a two-stop frame the first stop sample was stored during the first stop bit
        first_stop = ((STOP_BITS == 1) || !stop_q) ? maj : stop0_q;
        fr_err     = ferr_q | ~maj;
        par_err    = (PARITY != 0) && ((^data_q ^ pbit_q) != (PARITY == 1));
        is_brk     = (data_q == '0) && ((PARITY == 0) || !pbit_q) && !first_stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sync_q <= 2'b11;
        else if (uart_rx_en) sync_q <= {sync_q[0], uart_rxd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            smp_q      <= 2'b11;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            pbit_q     <= 1'b0;
            stop0_q    <= 1'b1;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            brk_q <= 1'b0;
            ovr_q <= 1'b0;
            if (valid_q && rx_ready) valid_q <= 1'b0;

            if (state_q != S_IDLE && state_q != S_BREAK) begin
                cnt_q <= at_end ? '0 : cnt_q + 1'b1;
                if (cnt_q == C_S0) smp_q[0] <= rxs;
                if (cnt_q == C_S1) smp_q[1] <= rxs;
            end

            if (!uart_rx_en) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (!rxs) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                    S_START: begin
                        if (at_dec && maj) state_q <= S_IDLE;
                        else if (at_end) begin
                            state_q <= S_DATA;
                            bit_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (at_dec) data_q <= {maj, data_q[PAYLOAD_BITS-1:1]};
                        if (at_end) begin
                            if (bit_q == B_LAST) begin
                                state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                                stop_q  <= 1'b0;
                                ferr_q  <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (at_dec) pbit_q  <= maj;
                        if (at_end) state_q <= S_STOP;
                    end
                    S_STOP: begin
                        // Completing at mid-bit leaves half a bit to catch the next start edge
                        if (at_dec && last_stop) begin
                            if (is_brk) begin
                                state_q <= S_BREAK;
                                brk_q   <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                if (!valid_q || rx_ready) begin
                                    valid_q    <= 1'b1;
                                    dout_q     <= data_q;
                                    perr_out_q <= par_err;
                                    ferr_out_q <= fr_err;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end
                        end else if (at_dec) begin
                            stop0_q <= maj;
                            ferr_q  <= ferr_q | ~maj;
                        end else if (at_end) begin
                            stop_q <= 1'b1;
                        end
                    end
                    S_BREAK: if (rxs) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_valid      = valid_q;
    assign rx_data       = dout_q;
    assign rx_parity_err = perr_out_q;
    assign rx_frame_err  = ferr_out_q;
    assign rx_break      = brk_q;
    assign rx_overrun    = ovr_q;
endmodule
